updn_counter_sequencer: RTL
===========================

Name: updn_counter_sequencer

Overview:
- Controller that sequences the 16-bit up/down counter (active-low synchronous load, count enable, up/down select, async active-low reset to 0).
- Takes a programmed start/end range, loads the counter and runs it to the end value. Optionally bounces between the endpoints for a set number of legs.
- Signals completion with a one-cycle pulse. Sits between the configuration/control logic and the counter instance.

Parameters:
- WIDTH, 16, counter data width.
- LEG_W, 8, width of the leg count config and status.

Ports:
- pclk  input  1  clock, rising edge.
- prst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request. Sampled only in IDLE.
- abort  input  1  terminates any operation. Highest priority after reset.
- pause  input  1  holds counting while high (RUN only).
- cfg_start  input  WIDTH  value loaded into the counter.
- cfg_end  input  WIDTH  target value.
- cfg_bounce  input  1  1 = ping-pong between endpoints.
- cfg_legs  input  LEG_W  total legs in bounce mode. 0 is treated as 1.
- cnt_value  input  WIDTH  counter output, fed back.
- ld_cnt  output  1  counter load, active low.
- count_enb  output  1  counter enable.
- updn_cnt  output  1  1 = up, 0 = down.
- data_in  output  WIDTH  counter load data.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  one-cycle pulse on abort.
- leg_cnt  output  LEG_W  legs completed in the current/last operation.

Behaviour:
- Reset (prst low, async): state IDLE; ld_cnt=1, count_enb=0, updn_cnt=1, data_in=0, busy=0, done=0, aborted=0, leg_cnt=0. Internal registers cleared.
- Configuration handling:
  - On start in IDLE, latch cfg_* into internal registers.
  - Direction: dir=up if cfg_end > cfg_start (unsigned), otherwise down.
  - target = cfg_end.
  - Non-bounce mode: legs = 1.
  - cfg_* changes during an operation are ignored.
- States and transitions:
  - IDLE: ld_cnt=1, count_enb=0. start → LOAD.
  - LOAD (exactly 1 cycle): ld_cnt=0, data_in=latched start, count_enb=0. → RUN.
  - RUN:
    - ld_cnt=1; updn_cnt=dir.
    - count_enb = !pause && (cnt_value != target). Combinational from registered state and cnt_value.
    - When cnt_value == target: leg_cnt increments.
    - If leg_cnt+1 == legs → DONE.
    - Otherwise turn around: swap target with the other endpoint and invert dir. count_enb is 0 in that cycle, giving a 1-cycle dwell at the endpoint. Stay in RUN.
  - DONE (1 cycle): done=1, count_enb=0. → IDLE.
- Abort: any non-IDLE state → IDLE at the next edge. aborted=1 for that one cycle. No done pulse. Counter value is left as is. leg_cnt holds.
- Priority: reset > abort > pause > normal sequencing.
- Start handling: start while busy is ignored. start in the same cycle the FSM returns to IDLE from DONE is ignored (it is not sampled).
- Range and wrap:
  - The counter never wraps; all moves stay inside [min(start,end), max(start,end)].
  - start == end: LOAD, one RUN cycle with count_enb=0, then DONE. Bounce with equal endpoints completes one leg per cycle.
- Latency, non-bounce, N = |end-start|, start sampled at edge 0:
  - ld_cnt low in cycle 1.
  - count_enb high for cycles 2..N+1.
  - cnt_value == end in cycle N+2.
  - done in cycle N+3.
  - busy high for cycles 1..N+3.
- Pause: each pause cycle in RUN extends completion by exactly one cycle. Pause has no effect in LOAD or DONE.
- Reset mid-operation: FSM returns to IDLE asynchronously. The counter is also cleared to 0 by the shared prst.

Test Plan:
1. start=5, end=9, bounce=0 → ld_cnt low 1 cycle with data_in=5; count_enb=1, updn_cnt=1 for 4 cycles; cnt_value=9; done pulse 1 cycle later; leg_cnt=1.
2. start=9, end=5 → updn_cnt=0, count_enb high 4 cycles, cnt_value=5, done. Also start=end=0xFFFF → no count cycles, done 3 cycles after start, no wrap to 0.
3. bounce=1, start=2, end=4, legs=3 → cnt_value sequence 2,3,4,4(dwell),3,2,2(dwell),3,4; then done; leg_cnt=3. legs=0 → behaves as 1 leg.
4. start=0, end=10, pause high for 3 cycles mid-run → count_enb low exactly 3 cycles; done arrives at cycle 16 instead of 13; final value 10.
5. Abort at cnt_value=6 of a 0→10 run → aborted pulse, no done, busy=0 next cycle, count_enb=0, cnt_value stays 6. start asserted while busy → ignored, sequence unchanged.
6. prst low mid-run → all outputs at reset values immediately; after release, IDLE and start works normally from cnt_value=0.

Source files
------------

// File: rtl/updn_counter_sequencer.sv
// updn_counter_sequencer: loads an external up/down counter and runs it between programmed endpoints,
// optionally bouncing back and forth for a set number of legs.
module updn_counter_sequencer #(
    parameter int WIDTH = 16,
    parameter int LEG_W = 8
) (
    input  logic             pclk,
    input  logic             prst,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_end,
    input  logic             cfg_bounce,
    input  logic [LEG_W-1:0] cfg_legs,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             ld_cnt,
    output logic             count_enb,
    output logic             updn_cnt,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LEG_W-1:0] leg_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic dir;
    logic [WIDTH-1:0] target, other;
    logic [LEG_W-1:0] legs;
    logic at_tgt, leg_last, leg_step;
    assign at_tgt   = cnt_value == target;
    assign leg_last = LEG_W'(leg_cnt + 1'b1) == legs;
    assign leg_step = state == RUN && !abort && !pause && at_tgt;
    assign busy     = state != IDLE;
    assign updn_cnt = dir;
    // abort masks every strobe so the counter freezes on the abort cycle itself
    always_comb begin
        state_nxt = state;
        ld_cnt    = 1'b1;
        count_enb = 1'b0;
        done      = 1'b0;
        aborted   = 1'b0;
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            aborted   = 1'b1;
        end else begin
            case (state)
                IDLE: state_nxt = start ? LOAD : IDLE;
                LOAD: begin
                    ld_cnt    = 1'b0;
                    state_nxt = RUN;
                end
                RUN: begin
                    count_enb = !pause && !at_tgt;
                    state_nxt = (leg_step && leg_last) ? DONE : RUN;
                end
                default: begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) state <= IDLE;
        else       state <= state_nxt;
    end
    // turnaround swaps endpoints; the at-target cycle doubles as the dwell
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            dir     <= 1'b1;
            target  <= '0;
            other   <= '0;
            data_in <= '0;
            legs    <= '0;
            leg_cnt <= '0;
        end else if (state == IDLE && start) begin
            dir     <= cfg_end > cfg_start;
            target  <= cfg_end;
            other   <= cfg_start;
            data_in <= cfg_start;
            legs    <= (cfg_bounce && cfg_legs != '0) ? cfg_legs : LEG_W'(1);
            leg_cnt <= '0;
        end else if (leg_step) begin
            leg_cnt <= LEG_W'(leg_cnt + 1'b1);
            if (!leg_last) begin
                target <= other;
                other  <= target;
                dir    <= !dir;
            end
        end
    end
endmodule
